// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for the write-back arbiter: pipe write, long-latency issue/result,
// register-file write port and hazard-unit status.
interface wb_write_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pipe_we;
  logic [4:0]        pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_issue;
  logic [4:0]        lu_issue_addr;
  logic              lu_valid;
  logic [4:0]        lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              RegWriteWB;
  logic [4:0]        regwriteaddrWB;
  logic [DATA_W-1:0] regwritedataWB;
  logic [31:0]       busy_mask;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  lu_issue, lu_issue_addr,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready,
    output RegWriteWB, regwriteaddrWB, regwritedataWB,
    output busy_mask, fifo_count
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output lu_issue, lu_issue_addr,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready,
    input  RegWriteWB, regwriteaddrWB, regwritedataWB,
    input  busy_mask, fifo_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: in-order pipe writes take absolute priority,
// long-latency results queue in a small FIFO and drain in bubbles.
module wb_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  wb_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [31:0] reg_bit(input logic [4:0] r);
    reg_bit = 32'd1 << r;
  endfunction

  logic [4:0]        addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              pipe_sel;
  logic              lu_ready;
  logic              push;
  logic              store;
  logic              pop;
  logic [31:0]       set_mask;
  logic [31:0]       clr_mask;

  logic              we_p1;
  logic [4:0]        addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [31:0]       busy_p1;

  // Writes to r0 are architecturally void, so they leave the slot free for a pop.
  assign pipe_sel = bus.pipe_we && (bus.pipe_addr != 5'd0);
  assign lu_ready = count < CNT_W'(DEPTH);
  assign push     = bus.lu_valid && lu_ready;
  assign store    = push && (bus.lu_addr != 5'd0);
  assign pop      = !pipe_sel && (count != '0);

  assign set_mask = bus.lu_issue ? reg_bit(bus.lu_issue_addr) : 32'd0;
  assign clr_mask = pop ? reg_bit(addr_mem[rd_ptr]) : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)   rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({store, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      addr_mem[wr_ptr] <= bus.lu_addr;
      data_mem[wr_ptr] <= bus.lu_data;
    end
  end

  // Stage p1: registered write port and scoreboard (set beats clear on the same bit).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_p1   <= 1'b0;
      addr_p1 <= 5'd0;
      data_p1 <= '0;
      busy_p1 <= 32'd0;
    end else begin
      we_p1 <= pipe_sel || pop;
      if (pipe_sel) begin
        addr_p1 <= bus.pipe_addr;
        data_p1 <= bus.pipe_data;
      end else if (pop) begin
        addr_p1 <= addr_mem[rd_ptr];
        data_p1 <= data_mem[rd_ptr];
      end
      busy_p1 <= ((busy_p1 & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  assign bus.lu_ready       = lu_ready;
  assign bus.RegWriteWB     = we_p1;
  assign bus.regwriteaddrWB = addr_p1;
  assign bus.regwritedataWB = data_p1;
  assign bus.busy_mask      = busy_p1;
  assign bus.fifo_count     = count;
endmodule
